wb_bus_arbiter: RTL and testbench

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

---
 rtl/wb_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_arbiter
// Brief    : Two-master Wishbone arbiter onto a single shared slave, with
//            alternating priority on contention and a stalled-cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic            busy_o,
  output logic            timeout_o
);

  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_last;
  logic [7:0] r_stall_cnt;

  logic w_own0;
  logic w_own1;
  logic w_stb;
  logic w_stall;
  logic w_tmo;

  // Ownership is masked by rst so every output is quiet while reset is held.
  assign w_own0  = (r_state == S_OWN0) && !rst;
  assign w_own1  = (r_state == S_OWN1) && !rst;
  assign w_stb   = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
  assign w_stall = w_stb & ~s_ack_i & ~s_err_i;
  assign w_tmo   = w_stall && (r_stall_cnt == C_TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_stall_cnt <= 8'd0;
    end else begin
      r_stall_cnt <= (w_stall && !w_tmo) ? r_stall_cnt + 8'd1 : 8'd0;
      case (r_state)
        S_IDLE: begin
          // On contention the master that did not own the bus last wins.
          if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
            r_state <= S_OWN0;
          end else if (m1_cyc_i) begin
            r_state <= S_OWN1;
          end
        end
        S_OWN0: begin
          if (!m0_cyc_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b0;
          end
        end
        S_OWN1: begin
          if (!m1_cyc_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_cyc_o = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
  assign s_stb_o = w_stb & ~w_tmo;
  assign s_we_o  = (w_own0 & m0_we_i) | (w_own1 & m1_we_i);
  assign s_adr_o = ({AW{w_own0}} & m0_adr_i) | ({AW{w_own1}} & m1_adr_i);
  assign s_dat_o = ({DW{w_own0}} & m0_dat_i) | ({DW{w_own1}} & m1_dat_i);
  assign s_sel_o = ({(DW/8){w_own0}} & m0_sel_i) | ({(DW/8){w_own1}} & m1_sel_i);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & w_own0 & m0_stb_i;
  assign m1_ack_o = s_ack_i & w_own1 & m1_stb_i;
  assign m0_err_o = (s_err_i | w_tmo) & w_own0 & m0_stb_i;
  assign m1_err_o = (s_err_i | w_tmo) & w_own1 & m1_stb_i;

  assign busy_o    = (r_state != S_IDLE) && !rst;
  assign timeout_o = w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bus_arbiter
// Brief    : Directed scenarios plus random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, busy_o, timeout_o;

  wb_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: owner is -1 (nobody), 0 or 1; stall is the run length.
  int m_owner = -1;
  int m_last = 1;
  int m_stall = 0;

  logic o_scyc, o_sstb, o_ack0, o_err0, o_ack1, o_err1, o_busy, o_tmo;
  logic [AW-1:0] o_adr;
  logic [DW-1:0] o_dat0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at negedge with inputs already driven; checks, then advances one clock.
  task automatic step();
    int o;
    logic ostb, ocyc, e_tmo;
    #1;
    o = rst ? -1 : m_owner;
    ostb = (o == 0) ? m0_stb_i : (o == 1) ? m1_stb_i : 1'b0;
    ocyc = (o == 0) ? m0_cyc_i : (o == 1) ? m1_cyc_i : 1'b0;
    e_tmo = (o >= 0) && ostb && !s_ack_i && !s_err_i && (m_stall == TIMEOUT - 1);
    chk("s_cyc", 64'(s_cyc_o), 64'(ocyc));
    chk("s_stb", 64'(s_stb_o), 64'(ostb && !e_tmo));
    chk("s_we", 64'(s_we_o), 64'((o == 0) ? m0_we_i : (o == 1) ? m1_we_i : 1'b0));
    chk("s_adr", 64'(s_adr_o), 64'((o == 0) ? m0_adr_i : (o == 1) ? m1_adr_i : '0));
    chk("s_dat", 64'(s_dat_o), 64'((o == 0) ? m0_dat_i : (o == 1) ? m1_dat_i : '0));
    chk("s_sel", 64'(s_sel_o), 64'((o == 0) ? m0_sel_i : (o == 1) ? m1_sel_i : '0));
    chk("m_dat", 64'({m0_dat_o, m1_dat_o}), 64'({s_dat_i, s_dat_i}));
    chk("ack0", 64'(m0_ack_o), 64'((o == 0) && m0_stb_i && s_ack_i));
    chk("ack1", 64'(m1_ack_o), 64'((o == 1) && m1_stb_i && s_ack_i));
    chk("err0", 64'(m0_err_o), 64'((o == 0) && m0_stb_i && (s_err_i || e_tmo)));
    chk("err1", 64'(m1_err_o), 64'((o == 1) && m1_stb_i && (s_err_i || e_tmo)));
    chk("busy", 64'(busy_o), 64'(o >= 0));
    chk("timeout", 64'(timeout_o), 64'(e_tmo));
    o_scyc = s_cyc_o; o_sstb = s_stb_o; o_busy = busy_o; o_tmo = timeout_o;
    o_ack0 = m0_ack_o; o_err0 = m0_err_o; o_ack1 = m1_ack_o; o_err1 = m1_err_o;
    o_adr = s_adr_o; o_dat0 = m0_dat_o;
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_last = 1; m_stall = 0;
    end else if (m_owner < 0) begin
      m_stall = 0;
      if (m0_cyc_i && m1_cyc_i) m_owner = (m_last == 1) ? 0 : 1;
      else if (m0_cyc_i) m_owner = 0;
      else if (m1_cyc_i) m_owner = 1;
    end else begin
      m_stall = (ostb && !s_ack_i && !s_err_i && !e_tmo) ? m_stall + 1 : 0;
      if (!ocyc) begin
        m_last = m_owner;
        m_owner = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_payload();
    m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
    m0_adr_i = $urandom; m1_adr_i = $urandom;
    m0_dat_i = $urandom; m1_dat_i = $urandom;
    m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
    s_dat_i = $urandom;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    s_ack_i = 0; s_err_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); rst = 0;
  endtask

  int grants[$];
  int prev, stall_n;
  logic hit;

  initial begin
    rst = 1;
    idle_inputs();
    rand_payload();
    @(negedge clk);
    // Reset state with random junk on the master ports.
    m0_cyc_i = 1; m1_cyc_i = 1; m0_stb_i = 1; m1_stb_i = 1; s_ack_i = 1; s_err_i = 1;
    step(); step();
    do_reset();

    // Single m0 read acked on its second strobe cycle.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
    step();
    chk("req047_idle_cyc", 64'(o_scyc), 64'(0));
    step();
    chk("req047_grant_cyc", 64'(o_scyc), 64'(1));
    s_ack_i = 1; s_dat_i = 32'h0000_0013;
    step();
    chk("req047_ack", 64'(o_ack0), 64'(1));
    chk("req047_dat", 64'(o_dat0), 64'h13);
    idle_inputs();
    step(); step();

    // Simultaneous request after reset: m0 first, then one idle cycle, then m1.
    do_reset();
    rand_payload();
    m0_cyc_i = 1; m1_cyc_i = 1;
    step();
    step();
    chk("req048_own0_adr", 64'(o_adr), 64'(m0_adr_i));
    m0_cyc_i = 0;
    step();
    step();
    chk("req048_idle_gap", 64'(o_busy), 64'(0));
    step();
    chk("req048_own1_adr", 64'({o_busy, o_adr}), 64'({1'b1, m1_adr_i}));
    idle_inputs();
    step(); step();

    // Continuous requests with one-cycle transfers alternate the grant.
    do_reset();
    s_ack_i = 1;
    o_ack0 = 0; o_ack1 = 0;
    for (int i = 0; i < 24; i++) begin
      m0_cyc_i = !o_ack0; m0_stb_i = m0_cyc_i;
      m1_cyc_i = !o_ack1; m1_stb_i = m1_cyc_i;
      prev = m_owner;
      step();
      if (prev < 0 && m_owner >= 0) grants.push_back(m_owner);
    end
    chk("req049_grant_count", 64'(grants.size() >= 4), 64'(1));
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("req049_order", 64'(grants[i]), 64'(i % 2));
    idle_inputs();
    step(); step();

    // m1 write to a slave that never answers: timeout on the 255th stalled cycle.
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
    stall_n = 0; hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      prev = m_owner;
      step();
      if (prev == 1) stall_n++;
      hit = o_tmo;
    end
    chk("req050_stall_cycles", 64'(stall_n), 64'(255));
    chk("req050_err_stb", 64'({o_err1, o_sstb}), 64'({1'b1, 1'b0}));
    step();
    chk("req050_after_tmo", 64'({o_tmo, o_err1}), 64'(0));
    idle_inputs();
    step(); step();

    // Slave acks on exactly the cycle that would time out: ack wins.
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
    stall_n = 0;
    for (int i = 0; i < 300 && stall_n < 255; i++) begin
      prev = m_owner;
      s_ack_i = (prev == 1) && (stall_n == 254);
      step();
      if (prev == 1) stall_n++;
    end
    chk("req051_ack", 64'({o_ack1, o_err1, o_tmo}), 64'({1'b1, 1'b0, 1'b0}));
    idle_inputs();
    step(); step();

    // Reset during OWN1 with strobe pending abandons the transfer.
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1;
    step(); step();
    chk("req052_owned", 64'(o_busy), 64'(1));
    rst = 1; s_ack_i = 1;
    step();
    chk("req052_no_resp", 64'({o_ack1, o_err1}), 64'(0));
    rst = 0; s_ack_i = 0;
    step();
    chk("req052_released", 64'({o_busy, o_scyc}), 64'(0));
    idle_inputs();
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_payload();
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(3) != 0); else m0_cyc_i = ($urandom_range(2) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(3) != 0); else m1_cyc_i = ($urandom_range(2) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(3) != 0);
      s_ack_i = ($urandom_range(9) < 4);
      s_err_i = ($urandom_range(19) == 0);
      rst = ($urandom_range(49) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
